bin2bcd_seq: RTL and testbench

//  Iterative (shift-add-3 / double-dabble) binary-to-BCD converter feeding the seg7 digit decoders.

---
 rtl/bin2bcd_pkg.sv | 26 ++
 rtl/bin2bcd_add3.sv | 16 +
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 tb/tb_bin2bcd_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
// Included by bin2bcd_seq and bcd_add3.
package bin2bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t ADD3_MIN = 4'd5;

   // Number of decimal digits needed to show 2**w-1 (valid for w up to 62).
   function automatic int min_digits(int w);
      longint unsigned v;
      int              n;
      v = (64'd1 << w) - 64'd1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// Single-digit double-dabble adjust: digits of 5 or more get 3 added (4-bit modulo).
module bcd_add3
   import bin2bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);

   always_comb begin
      q = d;
      if (bcd_digit_t'(d) >= ADD3_MIN) begin
         q = d + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter with valid/ready on both sides.
// Optional leading-zero blank flags are enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int W      = 10,
   parameter int DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int AW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);

   if (DIGITS < min_digits(W)) begin : g_digits_check
      $error("bin2bcd_seq: DIGITS=%0d cannot represent 2**%0d-1", DIGITS, W);
   end

   bcd_state_t    state;
   bcd_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_adj;
   logic [AW-1:0] acc_shf;
   logic [W-1:0]  bin_sr;
   logic          run;
   logic          last_shift;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d (acc[4*g +: 4]),
         .q (acc_adj[4*g +: 4])
      );
   end

   // Next accumulator value: adjusted digits shifted left, taking the binary MSB in.
   assign acc_shf    = {acc_adj[AW-2:0], bin_sr[W-1]};
   assign last_shift = (state == SHIFT) && (cnt == CW'(1));

   // run holds in_ready low until the first clock after reset release.
   assign in_ready  = (state == IDLE) && run;
   assign out_valid = (state == DONE);

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_above;

   always_comb begin
      blank_nxt  = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above   = zero_above & (acc_shf[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_above;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid && run) state_nxt = SHIFT;
         SHIFT:   if (cnt == CW'(1))   state_nxt = DONE;
         DONE:    if (out_ready)       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         run     <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         bin_sr  <= '0;
         bcd_out <= '0;
`ifdef BIN2BCD_BLANK_EN
         blank   <= '0;
`endif
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
         if (state == IDLE && in_valid && run) begin
            bin_sr <= bin_in;
            acc    <= '0;
            cnt    <= CW'(W);
         end
         if (state == SHIFT) begin
            acc    <= acc_shf;
            bin_sr <= bin_sr << 1;
            cnt    <= cnt - CW'(1);
         end
         if (last_shift) begin
            bcd_out <= acc_shf;
`ifdef BIN2BCD_BLANK_EN
            blank   <= blank_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and sweep bench for bin2bcd_seq at W=10, DIGITS=4.
// Blank-flag checks are compiled in when BIN2BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;

   localparam int W      = 10;
   localparam int DIGITS = 4;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [W-1:0]        bin_in = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [4*DIGITS-1:0] bcd_out;
`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0]   blank;
   logic [DIGITS-1:0]   cap_blank;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out)
`ifdef BIN2BCD_BLANK_EN
      ,
      .blank     (blank)
`endif
   );

   typedef struct {
      logic [W-1:0] bin;
      logic [15:0]  bcd;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

`ifdef BIN2BCD_BLANK_EN
   function automatic logic [3:0] blank_model(logic [15:0] b);
      logic       z;
      logic [3:0] r;
      z = 1'b1;
      r = '0;
      for (int i = 3; i >= 1; i--) begin
         z    = z & (b[4*i +: 4] == 4'd0);
         r[i] = z;
      end
      return r;
   endfunction
`endif

   // One full handshake: wait ready, pulse valid, wait result, stall, retire.
   task automatic do_conv(input logic [W-1:0] v, input int stall,
                          output logic [15:0] res, output int lat, output logic ok);
      int n;
      ok = 1'b1;
      n  = 0;
      while (!in_ready && n < 50) begin
         step;
         n++;
      end
      if (n >= 50) ok = 1'b0;
      in_valid = 1'b1;
      bin_in   = v;
      step;
      in_valid = 1'b0;
      bin_in   = ~v;
      lat = 0;
      while (!out_valid && lat < 50) begin
         step;
         lat++;
      end
      for (int s = 0; s < stall; s++) begin
         step;
         if (!out_valid) ok = 1'b0;
      end
      res = bcd_out;
`ifdef BIN2BCD_BLANK_EN
      cap_blank = blank;
`endif
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      if (out_valid) ok = 1'b0;
   endtask

   initial begin
      logic [15:0] res;
      int          lat;
      logic        ok;
      int          bad;
      int          nres;
      int          idx;
      logic        acc_now;
      logic [15:0] b2b_res [3];
      int          b2b_t [3];
      logic [W-1:0] b2b_v [3];

      tbl[0]  = '{10'd0,    16'h0000};
      tbl[1]  = '{10'd1023, 16'h1023};
      tbl[2]  = '{10'd42,   16'h0042};
      tbl[3]  = '{10'd9,    16'h0009};
      tbl[4]  = '{10'd10,   16'h0010};
      tbl[5]  = '{10'd999,  16'h0999};
      tbl[6]  = '{10'd512,  16'h0512};
      tbl[7]  = '{10'd5,    16'h0005};
      tbl[8]  = '{10'd99,   16'h0099};
      tbl[9]  = '{10'd100,  16'h0100};
      tbl[10] = '{10'd1000, 16'h1000};
      tbl[11] = '{10'd255,  16'h0255};

      // Reset state
      step;
      step;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_bcd_out",   32'(bcd_out),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      reset_n = 1'b1;
      step;
      chk("rel_in_ready",  32'(in_ready),  32'd1);

      // Table vectors, one conversion each
      for (int i = 0; i < 12; i++) begin
         do_conv(tbl[i].bin, i % 3, res, lat, ok);
         chk($sformatf("tbl%0d_bcd", i), 32'(res), 32'(tbl[i].bcd));
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(W));
         chk($sformatf("tbl%0d_hs", i),  32'(ok),  32'd1);
`ifdef BIN2BCD_BLANK_EN
         chk($sformatf("tbl%0d_blank", i), 32'(cap_blank), 32'(blank_model(tbl[i].bcd)));
`endif
      end
      chk("idle_hold_bcd", 32'(bcd_out), 32'h0255);

      // Long out_ready stall; in_valid asserted but must be ignored
      in_valid = 1'b1;
      bin_in   = 10'd42;
      step;
      bin_in   = 10'd7;
      lat = 0;
      while (!out_valid && lat < 50) begin
         step;
         lat++;
      end
      chk("stall_lat", 32'(lat), 32'(W));
      bad = 0;
      for (int s = 0; s < 20; s++) begin
         step;
         if (!out_valid || in_ready || bcd_out !== 16'h0042) bad++;
      end
      chk("stall_hold", 32'(bad), 32'd0);
`ifdef BIN2BCD_BLANK_EN
      chk("stall_blank", 32'(blank), 32'b1100);
`endif
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      chk("retire_out_valid", 32'(out_valid), 32'd0);
      chk("retire_in_ready",  32'(in_ready),  32'd1);
      chk("retire_bcd_hold",  32'(bcd_out),   32'h0042);
      step;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         step;
         lat++;
      end
      chk("late_accept_lat", 32'(lat),     32'(W));
      chk("late_accept_bcd", 32'(bcd_out), 32'h0007);
      out_ready = 1'b1;
      step;

      // Back-to-back with in_valid and out_ready held high
      b2b_v[0] = 10'd9;
      b2b_v[1] = 10'd10;
      b2b_v[2] = 10'd999;
      idx      = 0;
      nres     = 0;
      in_valid = 1'b1;
      bin_in   = b2b_v[0];
      for (int c = 0; c < 200 && nres < 3; c++) begin
         acc_now = in_ready && in_valid;
         if (out_valid) begin
            b2b_res[nres] = bcd_out;
            b2b_t[nres]   = c;
            nres++;
         end
         step;
         if (acc_now) begin
            idx++;
            if (idx < 3) bin_in = b2b_v[idx];
            else in_valid = 1'b0;
         end
      end
      out_ready = 1'b0;
      chk("b2b_count", 32'(nres), 32'd3);
      if (nres == 3) begin
         chk("b2b_res0", 32'(b2b_res[0]), 32'h0009);
         chk("b2b_res1", 32'(b2b_res[1]), 32'h0010);
         chk("b2b_res2", 32'(b2b_res[2]), 32'h0999);
         chk("b2b_gap1", 32'(b2b_t[1] - b2b_t[0]), 32'(W + 2));
         chk("b2b_gap2", 32'(b2b_t[2] - b2b_t[1]), 32'(W + 2));
      end

      // Asynchronous reset in the middle of a conversion
      while (!in_ready) step;
      in_valid = 1'b1;
      bin_in   = 10'd512;
      step;
      in_valid = 1'b0;
      repeat (5) step;
      reset_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_bcd_out",   32'(bcd_out),   32'd0);
      chk("abort_in_ready",  32'(in_ready),  32'd0);
      repeat (2) step;
      reset_n = 1'b1;
      step;
      chk("abort_rel_ready", 32'(in_ready), 32'd1);
      do_conv(10'd512, 1, res, lat, ok);
      chk("abort_new_bcd", 32'(res), 32'h0512);
      chk("abort_new_lat", 32'(lat), 32'(W));

      // Full sweep with random stalls
      bad = 0;
      for (int v = 0; v < 1024; v++) begin
         do_conv(10'(v), int'($urandom_range(0, 3)), res, lat, ok);
         chk($sformatf("sweep_%0d", v), 32'(res), 32'(model(v)));
         if (lat != W || !ok) bad++;
      end
      chk("sweep_handshake", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
